// File: rtl/bin_bcd_serial.sv
// Serial binary-to-BCD converter (double dabble), one shift per clock.
// A BIN_W-bit value is converted in BIN_W cycles; results that do not fit in DIG_N digits saturate to all nines.

module bin_bcd_digit (
  input  logic [3:0] dig_i,
  output logic [3:0] adj_o
);
  assign adj_o = (dig_i >= 4'd5) ? dig_i + 4'd3 : dig_i;
endmodule

module bin_bcd_serial #(
  parameter int BIN_W = 8,
  parameter int DIG_N = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din_vld,
  input  logic [BIN_W-1:0]   bin_in,
  output logic               din_rdy,
  output logic [4*DIG_N-1:0] bcd_out,
  output logic               dout_vld,
  output logic               ovf
);
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);
  localparam logic [4*DIG_N-1:0] SAT = {DIG_N{4'h9}};

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                   state_q, state_d;
  logic [BIN_W-1:0]         bin_q, bin_d;
  logic [DIG_N-1:0][3:0]    bcd_q, bcd_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     sovf_q, sovf_d;
  logic [4*DIG_N-1:0]       out_q, out_d;
  logic                     ovf_q, ovf_d;
  logic                     dvld_q, dvld_d;

  logic [DIG_N-1:0][3:0]    adj;
  logic [4*DIG_N:0]         shifted;

  for (genvar g = 0; g < DIG_N; g++) begin : g_dig
    bin_bcd_digit u_dig (.dig_i(bcd_q[g]), .adj_o(adj[g]));
  end

  // Top bit of shifted is what falls out of the most significant digit.
  assign shifted = {adj, bin_q[BIN_W-1]};

  assign din_rdy  = (state_q == IDLE);
  assign bcd_out  = out_q;
  assign ovf      = ovf_q;
  assign dout_vld = dvld_q;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    sovf_d  = sovf_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    dvld_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (din_vld) begin
          bin_d   = bin_in;
          bcd_d   = '0;
          cnt_d   = '0;
          sovf_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bin_d  = {bin_q[BIN_W-2:0], 1'b0};
        bcd_d  = shifted[4*DIG_N-1:0];
        sovf_d = sovf_q | shifted[4*DIG_N];
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = IDLE;
          out_d   = sovf_d ? SAT : shifted[4*DIG_N-1:0];
          ovf_d   = sovf_d;
          dvld_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      sovf_q  <= 1'b0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      dvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      sovf_q  <= sovf_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      dvld_q  <= dvld_d;
    end
  end
endmodule

// File: tb/tb_bin_bcd_serial.sv
// Directed bench for bin_bcd_serial: three configurations (8/3, 8/2, 16/5) sharing one clock and reset.

module tb_bin_bcd_serial;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        vA, vB, vC;
  logic [7:0]  binA, binB;
  logic [15:0] binC;
  logic        rdyA, rdyB, rdyC;
  logic [11:0] bcdA;
  logic [7:0]  bcdB;
  logic [19:0] bcdC;
  logic        dvA, dvB, dvC, ovfA, ovfB, ovfC;

  bin_bcd_serial #(.BIN_W(8), .DIG_N(3)) u_a (
    .clk(clk), .rst_n(rst_n), .din_vld(vA), .bin_in(binA), .din_rdy(rdyA),
    .bcd_out(bcdA), .dout_vld(dvA), .ovf(ovfA));
  bin_bcd_serial #(.BIN_W(8), .DIG_N(2)) u_b (
    .clk(clk), .rst_n(rst_n), .din_vld(vB), .bin_in(binB), .din_rdy(rdyB),
    .bcd_out(bcdB), .dout_vld(dvB), .ovf(ovfB));
  bin_bcd_serial #(.BIN_W(16), .DIG_N(5)) u_c (
    .clk(clk), .rst_n(rst_n), .din_vld(vC), .bin_in(binC), .din_rdy(rdyC),
    .bcd_out(bcdC), .dout_vld(dvC), .ovf(ovfC));

  int          sel_g;
  logic        dv_s, ovf_s;
  logic [19:0] bcd_s;
  always_comb begin
    dv_s = dvA; ovf_s = ovfA; bcd_s = {8'h0, bcdA};
    case (sel_g)
      1: begin dv_s = dvB; ovf_s = ovfB; bcd_s = {12'h0, bcdB}; end
      2: begin dv_s = dvC; ovf_s = ovfC; bcd_s = bcdC; end
      default: ;
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setin(input int sel, input logic v, input logic [15:0] b);
    case (sel)
      0: begin vA = v; binA = b[7:0]; end
      1: begin vB = v; binB = b[7:0]; end
      default: begin vC = v; binC = b; end
    endcase
  endtask

  // Accept one value, then count edges until dout_vld appears (bounded).
  task automatic conv(input int sel, input logic [15:0] b, output logic [19:0] bcd,
                      output logic o, output int lat);
    sel_g = sel;
    setin(sel, 1'b1, b);
    @(posedge clk); #1;
    setin(sel, 1'b0, b);
    lat = 0;
    while (!dv_s && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    bcd = bcd_s;
    o   = ovf_s;
  endtask

  function automatic logic [19:0] ref_bcd(input int v, input int dig, output logic o);
    logic [19:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < dig; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    o = (x != 0);
    if (o) for (int i = 0; i < dig; i++) r[4*i +: 4] = 4'h9;
    return r;
  endfunction

  typedef struct {
    int          sel;
    logic [15:0] bin;
    logic [19:0] bcd;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [19:0] bcd;
    logic        o, ro;
    int          lat, npulse, t1, t2;
    logic [19:0] b1, b2;

    vecs[0]  = '{0, 16'd255,   20'h00255, 1'b0, 8};
    vecs[1]  = '{0, 16'd0,     20'h00000, 1'b0, 8};
    vecs[2]  = '{0, 16'd9,     20'h00009, 1'b0, 8};
    vecs[3]  = '{0, 16'd10,    20'h00010, 1'b0, 8};
    vecs[4]  = '{0, 16'd199,   20'h00199, 1'b0, 8};
    vecs[5]  = '{1, 16'd100,   20'h00099, 1'b1, 8};
    vecs[6]  = '{1, 16'd42,    20'h00042, 1'b0, 8};
    vecs[7]  = '{1, 16'd255,   20'h00099, 1'b1, 8};
    vecs[8]  = '{1, 16'd99,    20'h00099, 1'b0, 8};
    vecs[9]  = '{2, 16'd65535, 20'h65535, 1'b0, 16};
    vecs[10] = '{2, 16'd12345, 20'h12345, 1'b0, 16};
    vecs[11] = '{2, 16'd0,     20'h00000, 1'b0, 16};
    vecs[12] = '{2, 16'd1000,  20'h01000, 1'b0, 16};

    rst_n = 1'b0; sel_g = 0;
    vA = 0; vB = 0; vC = 0; binA = 0; binB = 0; binC = 0;
    repeat (2) @(negedge clk);
    chk("rst_rdy",  rdyA, 1);
    chk("rst_bcd",  bcdA, 0);
    chk("rst_ovf",  ovfA, 0);
    chk("rst_dv",   dvA,  0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      conv(vecs[i].sel, vecs[i].bin, bcd, o, lat);
      chk($sformatf("vec%0d_bcd", i), bcd, vecs[i].bcd);
      chk($sformatf("vec%0d_ovf", i), o, vecs[i].ovf);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
    end

    // Input held during SHIFT is dropped; din_rdy stays low for 8 cycles.
    sel_g = 0;
    setin(0, 1'b1, 16'd99);
    @(posedge clk); #1;
    setin(0, 1'b1, 16'd7);
    npulse = 0;
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("drop_rdy%0d", c), rdyA, 0);
      if (dvA) npulse++;
      @(posedge clk); #1;
    end
    chk("drop_rdy_back", rdyA, 1);
    chk("drop_dv", dvA, 1);
    chk("drop_bcd", bcdA, 12'h099);
    if (dvA) npulse++;
    setin(0, 1'b0, 16'd0);
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (dvA) npulse++;
    end
    chk("drop_pulses", npulse, 1);
    chk("hold_bcd", bcdA, 12'h099);

    // Reset while the counter is at 4 aborts with no result.
    chk("pre_rst_bcd", bcdA, 12'h099);
    setin(0, 1'b1, 16'd200);
    @(posedge clk); #1;
    setin(0, 1'b0, 16'd0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_bcd", bcdA, 0);
    chk("mid_rst_ovf", ovfA, 0);
    chk("mid_rst_dv",  dvA,  0);
    chk("mid_rst_rdy", rdyA, 1);
    npulse = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (dvA) npulse++;
    end
    chk("mid_rst_pulses", npulse, 0);
    @(negedge clk);
    rst_n = 1'b1;
    conv(0, 16'd128, bcd, o, lat);
    chk("post_rst_bcd", bcd, 20'h00128);
    chk("post_rst_ovf", o, 0);
    chk("post_rst_lat", lat, 8);

    // Back-to-back with din_vld held: 99 then 100, pulses 9 cycles apart.
    sel_g = 0;
    setin(0, 1'b1, 16'd99);
    @(posedge clk); #1;
    setin(0, 1'b1, 16'd100);
    npulse = 0; t1 = -1; t2 = -1; b1 = '0; b2 = '0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c == 9) setin(0, 1'b0, 16'd0);
      if (dvA) begin
        npulse++;
        if (npulse == 1) begin t1 = c; b1 = {8'h0, bcdA}; end
        else begin t2 = c; b2 = {8'h0, bcdA}; end
      end
    end
    chk("b2b_pulses", npulse, 2);
    chk("b2b_t1", t1, 8);
    chk("b2b_gap", t2 - t1, 9);
    chk("b2b_bcd1", b1, 20'h00099);
    chk("b2b_bcd2", b2, 20'h00100);

    for (int v = 0; v < 256; v++) begin
      conv(0, 16'(v), bcd, o, lat);
      chk($sformatf("sweep%0d", v), {o, bcd}, {1'b0, ref_bcd(v, 3, ro)});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
